// File: rtl/carrd_vrf_commit_if.sv
// rtl/carrd_vrf_commit_if.sv - coprocessor writeback request channel
// Purpose: groups the writeback request signals and the ready return.
// Ports (modport master = producer, slave = carrd_vrf_commit):
//   wb_v_wr_en / wb_el_wr_en / wb_x_wr_en : request enables (v > el > x)
//   wb_dest, wb_el_addr                   : destination and element index
//   wb_data_1..wb_data_4                  : result beats 0..3
//   wb_ready                              : request can be accepted this cycle
interface carrd_vrf_commit_if;
  logic         wb_v_wr_en;
  logic         wb_el_wr_en;
  logic         wb_x_wr_en;
  logic [4:0]   wb_dest;
  logic [4:0]   wb_el_addr;
  logic [127:0] wb_data_1;
  logic [127:0] wb_data_2;
  logic [127:0] wb_data_3;
  logic [127:0] wb_data_4;
  logic         wb_ready;

  modport master (
    output wb_v_wr_en, wb_el_wr_en, wb_x_wr_en, wb_dest, wb_el_addr,
           wb_data_1, wb_data_2, wb_data_3, wb_data_4,
    input  wb_ready
  );

  modport slave (
    input  wb_v_wr_en, wb_el_wr_en, wb_x_wr_en, wb_dest, wb_el_addr,
           wb_data_1, wb_data_2, wb_data_3, wb_data_4,
    output wb_ready
  );
endinterface

// File: rtl/carrd_vrf_commit.sv
// rtl/carrd_vrf_commit.sv - writeback request FIFO and VRF/XRF commit engine
// Purpose: queues writeback requests and commits them as VRF beats
// (4 per vector group, 1 masked per element) or a single XRF write,
// while exporting a per-register pending mask for hazard stalls.
// Ports:
//   clk, nrst             : clock, asynchronous active-low reset
//   wb (slave)            : writeback request channel
//   vrf_wr_en/addr/data/be: VRF write port
//   xrf_wr_en/addr/data   : XRF write port
//   vreg_pending          : bit r set while an uncommitted VRF beat targets r
//   busy                  : requests queued or a commit in progress
module carrd_vrf_commit #(
  parameter int DEPTH      = 2,
  parameter int VLEN_BEATS = 4
) (
  input  logic               clk,
  input  logic               nrst,
  carrd_vrf_commit_if.slave  wb,
  output logic               vrf_wr_en,
  output logic [4:0]         vrf_wr_addr,
  output logic [127:0]       vrf_wr_data,
  output logic [15:0]        vrf_wr_be,
  output logic               xrf_wr_en,
  output logic [4:0]         xrf_wr_addr,
  output logic [31:0]        xrf_wr_data,
  output logic [31:0]        vreg_pending,
  output logic               busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {K_V, K_EL, K_X} kind_t;
  typedef enum logic [1:0] {IDLE, VBEAT, ELEM, XREG} state_t;

  // The executing request stays at the FIFO head until its last beat, so
  // the FIFO count covers it and wb_ready drops after DEPTH accepts.
  kind_t                kind_mem [DEPTH];
  logic [4:0]           dest_mem [DEPTH];
  logic [4:0]           ela_mem  [DEPTH];
  logic [3:0][127:0]    data_mem [DEPTH];

  logic [AW-1:0]  wr_ptr, rd_ptr, nxt_ptr;
  logic [AW:0]    count, cnt_after;
  state_t         state, state_d;
  logic [1:0]     beat, beat_d;
  logic           ready, accept, last, free;
  kind_t          kind_in, nk;
  logic [4:0]     el_tgt;
  logic [31:0]    inc, dec;
  logic [CW-1:0]  pend_cnt [32];

  assign ready       = (count != (AW+1)'(DEPTH));
  assign wb.wb_ready = ready;
  assign accept      = ready && (wb.wb_v_wr_en || wb.wb_el_wr_en || wb.wb_x_wr_en);
  assign kind_in     = wb.wb_v_wr_en ? K_V : (wb.wb_el_wr_en ? K_EL : K_X);
  assign el_tgt      = wb.wb_dest + {2'b00, wb.wb_el_addr[4:2]};

  always_ff @(posedge clk) begin
    if (accept) begin
      kind_mem[wr_ptr] <= kind_in;
      dest_mem[wr_ptr] <= wb.wb_dest;
      ela_mem[wr_ptr]  <= wb.wb_el_addr;
      if (kind_in == K_V)
        data_mem[wr_ptr] <= {wb.wb_data_4, wb.wb_data_3, wb.wb_data_2, wb.wb_data_1};
      else
        data_mem[wr_ptr] <= {384'd0, 96'd0, wb.wb_data_1[31:0]};
    end
  end

  // Next-request selection looks past the entry being popped; when nothing
  // else is queued the request accepted on this same edge starts directly.
  always_comb begin
    state_d   = state;
    beat_d    = beat;
    last      = (state == VBEAT && beat == 2'(VLEN_BEATS - 1)) ||
                state == ELEM || state == XREG;
    free      = (state == IDLE) || last;
    cnt_after = count - (AW+1)'(last);
    nxt_ptr   = rd_ptr + AW'(last);
    nk        = (cnt_after != '0) ? kind_mem[nxt_ptr] : kind_in;
    if (free) begin
      beat_d = 2'd0;
      if (cnt_after != '0 || accept) begin
        case (nk)
          K_V:     state_d = VBEAT;
          K_EL:    state_d = ELEM;
          default: state_d = XREG;
        endcase
      end else begin
        state_d = IDLE;
      end
    end else begin
      beat_d = beat + 2'd1;
    end
  end

  always_comb begin
    vrf_wr_en   = 1'b0;
    vrf_wr_addr = 5'd0;
    vrf_wr_data = 128'd0;
    vrf_wr_be   = 16'd0;
    xrf_wr_en   = 1'b0;
    xrf_wr_addr = 5'd0;
    xrf_wr_data = 32'd0;
    case (state)
      VBEAT: begin
        vrf_wr_en   = 1'b1;
        vrf_wr_addr = dest_mem[rd_ptr] + {3'b000, beat};
        vrf_wr_data = data_mem[rd_ptr][beat];
        vrf_wr_be   = 16'hFFFF;
      end
      ELEM: begin
        vrf_wr_en   = 1'b1;
        vrf_wr_addr = dest_mem[rd_ptr] + {2'b00, ela_mem[rd_ptr][4:2]};
        vrf_wr_data = {4{data_mem[rd_ptr][0][31:0]}};
        vrf_wr_be   = 16'h000F << {ela_mem[rd_ptr][1:0], 2'b00};
      end
      XREG: begin
        xrf_wr_en   = 1'b1;
        xrf_wr_addr = dest_mem[rd_ptr];
        xrf_wr_data = data_mem[rd_ptr][0][31:0];
      end
      default: ;
    endcase
  end

  // Per-register outstanding-beat counters: +1 per accepted beat targeting
  // r, -1 at the edge ending a committed beat to r.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      inc[r] = accept &&
               ((kind_in == K_V  && (5'(r) - wb.wb_dest) < 5'(VLEN_BEATS)) ||
                (kind_in == K_EL && 5'(r) == el_tgt));
      dec[r] = vrf_wr_en && (vrf_wr_addr == 5'(r));
      vreg_pending[r] = (pend_cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      beat   <= 2'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int r = 0; r < 32; r++) pend_cnt[r] <= '0;
    end else begin
      state <= state_d;
      beat  <= beat_d;
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (last)   rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(accept) - (AW+1)'(last);
      for (int r = 0; r < 32; r++) begin
        if (inc[r] && !dec[r])      pend_cnt[r] <= pend_cnt[r] + CW'(1);
        else if (dec[r] && !inc[r]) pend_cnt[r] <= pend_cnt[r] - CW'(1);
      end
    end
  end

  assign busy = (count != '0) || (state != IDLE);
endmodule

// File: doc/carrd_vrf_commit.md
Name: carrd_vrf_commit

Overview:
- Receiving end of the coprocessor writeback interface. Accepts one writeback request per handshake, buffers it, and commits it to the physical register files.
- A full vector result (4x128 = 512 bits, one 4-register group) goes to the 128-bit single-write-port VRF as 4 beats. Element results go as one masked beat. Scalar results go to the XRF.
- Exports a per-register pending mask so the decode/issue logic can stall on RAW hazards.

Parameters:
- DEPTH, 2, request FIFO entries (power of two, >=2)
- VLEN_BEATS, 4, VRF beats per full vector write (fixed at 4 in this revision)

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- wb_v_wr_en  in  1  full vector-group write request
- wb_el_wr_en  in  1  single 32-bit element write request
- wb_x_wr_en  in  1  scalar register write request
- wb_dest  in  5  destination register (vector group base or x register)
- wb_el_addr  in  5  element index within group, for el writes
- wb_data_1..wb_data_4  in  128 each  result beats 0..3
- wb_ready  out  1  FIFO can accept a request this cycle
- vrf_wr_en  out  1  VRF write strobe
- vrf_wr_addr  out  5  VRF register address
- vrf_wr_data  out  128  VRF write data
- vrf_wr_be  out  16  VRF byte enables
- xrf_wr_en  out  1  XRF write strobe
- xrf_wr_addr  out  5  XRF address
- xrf_wr_data  out  32  XRF data
- vreg_pending  out  32  bit r=1 while an accepted, uncommitted VRF beat targets register r
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (nrst=0, async): FIFO empty; FSM IDLE; all outputs 0 except wb_ready=1. Reset mid-commit discards all queued and in-progress writes with no partial beat emitted after reset.
- Accept: at a rising edge where wb_ready=1 and any enable is 1, exactly one request is enqueued. Priority is v > el > x; lower-priority enables in the same cycle are dropped.
- Enables asserted while wb_ready=0 are ignored; the producer must hold them.
- wb_ready = !full, registered-free combinational from FIFO count.
- Stored per entry: kind, dest, el_addr, data_1..4. For x and el requests only data_1[31:0] is stored.
- FSM states: IDLE, VBEAT, ELEM, XREG. In IDLE with a non-empty FIFO it pops the head and enters the state for its kind.
  - Earliest first write strobe: the cycle after the accepting edge.
  - VBEAT: 4 consecutive cycles with vrf_wr_en=1, beat k=0..3, vrf_wr_addr=(dest+k) mod 32, vrf_wr_data=data_(k+1), vrf_wr_be=16'hFFFF.
  - ELEM: 1 cycle. vrf_wr_addr=(dest+el_addr[4:2]) mod 32; data is data_1[31:0] replicated to all 4 words; vrf_wr_be=16'h000F << (4*el_addr[1:0]).
  - XREG: 1 cycle. xrf_wr_en=1, xrf_wr_addr=dest, xrf_wr_data=data_1[31:0]. A write with dest=0 is still issued; XRF ignores x0.
  - After the last beat of a request, the FSM goes back to IDLE for one cycle, or, if the FIFO is non-empty, starts the next request with no gap (back-to-back).
- Strobes are 0 in every cycle not listed above; data/addr/be outputs are don't-care when their strobe is 0.
- Simultaneous accept and pop at a full FIFO: a pop in the same edge does not free space for that edge. wb_ready reflects the pre-edge count.
- Pending mask:
  - Set at the accepting edge for every target register: 4 for v (wrapping past 31), 1 for el.
  - A register's bit clears at the edge ending its last uncommitted beat across all entries.
  - Two queued entries targeting the same register keep its bit set until both have committed.
  - x writes never affect vreg_pending.
- Commit latency with an empty FIFO: vector 5 cycles accept-to-done; el/x 2 cycles.

Test Plan:
- Reset, then wb_v_wr_en, dest=4, data_k=128'hk... -> vrf beats addr 4,5,6,7 with data_1..4 on 4 consecutive cycles starting the cycle after accept; vreg_pending=32'h000000F0 then clears bit-by-bit; busy falls after the 4th beat.
- v write, dest=30 -> addresses 30,31,0,1; pending=32'hC0000003 on the accept edge.
- el write, dest=8, el_addr=5'd6, data_1[31:0]=32'hDEADBEEF -> one beat, addr 9, be=16'h0F00, word 2=DEADBEEF; pending bit 9 only.
- v, el, and x enables asserted together with dest=3 -> only the vector write is enqueued (4 beats); no XRF write occurs.
- DEPTH=2: three back-to-back v requests -> wb_ready=0 after two accepts; third accepted once a slot frees; 12 contiguous beats with no gaps.
- x write dest=5 data=32'h1234 followed by v write dest=5 -> XRF write at cycle 1, VRF beats at cycles 2-5. Separately, drop nrst during beat 2 of a v write -> outputs 0 immediately, pending=0, no further beats.
